// File: rtl/exp_lut_ctrl.sv
// exp_lut_ctrl: double-buffered loader for the exp interpolator curve table.
// Table words stream into a shadow bank; a complete table is copied into the
// active bank only on frame_start, so the datapath never sees a partial curve.
// Optional build macro: EXP_LUT_MONO_CHK_EN rejects loads whose curve is not
// non-increasing (entry k must be <= entry k-1).
module exp_lut_ctrl #(
    parameter int DW_Y    = 9,
    parameter int NUM     = 46,
    parameter int RST_VAL = 121
) (
    input  logic                  clk,
    input  logic                  rst_n,       // synchronous, active-high
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DW_Y-1:0]       cfg_data,
    input  logic                  cfg_last,
    input  logic                  frame_start,
    output logic [NUM*DW_Y-1:0]   lut_flat,
    output logic                  pending,
    output logic                  swap_done,
    output logic                  load_err,
    output logic [5:0]            wr_idx
);

    typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

    localparam logic [DW_Y-1:0] RST_WORD = DW_Y'(RST_VAL);
    localparam logic [5:0]      LAST_IDX = 6'(NUM - 1);

    state_t            r_state;
    logic [5:0]        r_wr_idx;
    logic              r_ready;
    logic              r_pending;
    logic              r_swap_done;
    logic              r_load_err;
    logic [DW_Y-1:0]   r_shadow [NUM];
    logic [DW_Y-1:0]   r_active [NUM];

    state_t            w_state_nxt;
    logic [5:0]        w_wr_idx_nxt;
    logic              w_err_nxt;
    logic              w_swap_en;
    logic              w_beat;
    logic              w_mono_bad;

    assign w_beat = cfg_valid && r_ready;

`ifdef EXP_LUT_MONO_CHK_EN
    logic [DW_Y-1:0]   r_prev;
    logic              r_mono_flag;

    // A word larger than its predecessor poisons the rest of the current load.
    assign w_mono_bad = r_mono_flag || (cfg_data > r_prev);

    // Track the previous word and the sticky ordering-violation flag.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_prev      <= '0;
            r_mono_flag <= 1'b0;
        end else begin
            if (w_beat) begin
                r_prev <= cfg_data;
            end
            if (w_state_nxt != LOAD) begin
                r_mono_flag <= 1'b0;
            end else if (w_beat && r_state == LOAD) begin
                r_mono_flag <= w_mono_bad;
            end
        end
    end
`else
    assign w_mono_bad = 1'b0;
`endif

    // Next-state logic: load sequencing, malformed-load detection, swap request.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_idx_nxt = r_wr_idx;
        w_err_nxt    = 1'b0;
        w_swap_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_beat) begin
                    if (NUM == 1) begin
                        // A one-entry table is complete after a single word.
                        w_wr_idx_nxt = 6'd0;
                        if (cfg_last) begin
                            w_state_nxt = PEND;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else if (cfg_last) begin
                        w_err_nxt    = 1'b1;
                        w_wr_idx_nxt = 6'd0;
                    end else begin
                        w_state_nxt  = LOAD;
                        w_wr_idx_nxt = 6'd1;
                    end
                end
            end
            LOAD: begin
                if (w_beat) begin
                    if (r_wr_idx == LAST_IDX) begin
                        // Final slot: only a last-marked, well-ordered word completes the table.
                        w_wr_idx_nxt = 6'd0;
                        if (cfg_last && !w_mono_bad) begin
                            w_state_nxt = PEND;
                        end else begin
                            w_state_nxt = IDLE;
                            w_err_nxt   = 1'b1;
                        end
                    end else if (cfg_last) begin
                        w_state_nxt  = IDLE;
                        w_err_nxt    = 1'b1;
                        w_wr_idx_nxt = 6'd0;
                    end else begin
                        w_wr_idx_nxt = r_wr_idx + 6'd1;
                    end
                end
            end
            PEND: begin
                if (frame_start) begin
                    w_swap_en   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_wr_idx_nxt = 6'd0;
            end
        endcase
    end

    // Control registers; all status outputs are registered copies of next-state decisions.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state     <= IDLE;
            r_wr_idx    <= 6'd0;
            r_ready     <= 1'b1;
            r_pending   <= 1'b0;
            r_swap_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_idx    <= w_wr_idx_nxt;
            r_ready     <= (w_state_nxt != PEND);
            r_pending   <= (w_state_nxt == PEND);
            r_swap_done <= w_swap_en;
            r_load_err  <= w_err_nxt;
        end
    end

    // Shadow bank: written one word per accepted beat at the current index.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NUM; k++) begin
                r_shadow[k] <= RST_WORD;
            end
        end else if (w_beat) begin
            r_shadow[r_wr_idx] <= cfg_data;
        end
    end

    // Active bank: whole-table copy from shadow in a single edge on swap.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NUM; k++) begin
                r_active[k] <= RST_WORD;
            end
        end else if (w_swap_en) begin
            r_active <= r_shadow;
        end
    end

    // Flatten the active bank onto the y1_k bus.
    always_comb begin
        lut_flat = '0;
        for (int k = 0; k < NUM; k++) begin
            lut_flat[k*DW_Y +: DW_Y] = r_active[k];
        end
    end

    assign cfg_ready = r_ready;
    assign pending   = r_pending;
    assign swap_done = r_swap_done;
    assign load_err  = r_load_err;
    assign wr_idx    = r_wr_idx;

endmodule

// File: tb/tb_exp_lut_ctrl.sv
// tb_exp_lut_ctrl: table-driven load scenarios with an event scoreboard for
// load_err / swap_done pulses, plus hand-written multi-cycle corner sequences.
module tb_exp_lut_ctrl;

    localparam int DW = 9;
    localparam int N  = 46;
    localparam int LW = N * DW;
`ifdef EXP_LUT_MONO_CHK_EN
    localparam bit MONO_ON = 1'b1;
`else
    localparam bit MONO_ON = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [DW-1:0]   cfg_data;
    logic            cfg_last;
    logic            frame_start;
    logic [LW-1:0]   lut_flat;
    logic            pending;
    logic            swap_done;
    logic            load_err;
    logic [5:0]      wr_idx;

    exp_lut_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .cfg_last    (cfg_last),
        .frame_start (frame_start),
        .lut_flat    (lut_flat),
        .pending     (pending),
        .swap_done   (swap_done),
        .load_err    (load_err),
        .wr_idx      (wr_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int nbeats;
        int last_at;
        int start;
        int step;
        int bump_idx;
        int bump_val;
        bit collide;
        bit exp_err;
        bit exp_pend;
    } vec_t;

    typedef struct {
        bit            is_swap;
        logic [LW-1:0] lut;
    } ev_t;

    vec_t          vt [9];
    ev_t           evq [$];
    int            n_chk  = 0;
    int            n_fail = 0;
    logic [LW-1:0] model;
    logic [LW-1:0] all_rst;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic chk_lut(input string nm, input logic [LW-1:0] exp);
        bit reported;
        reported = 1'b0;
        n_chk++;
        if (lut_flat !== exp) begin
            n_fail++;
            for (int k = 0; k < N; k++) begin
                if (!reported && lut_flat[k*DW +: DW] !== exp[k*DW +: DW]) begin
                    $display("FAIL %s: entry %0d got %0d, expected %0d",
                             nm, k, lut_flat[k*DW +: DW], exp[k*DW +: DW]);
                    reported = 1'b1;
                end
            end
            if (!reported) $display("FAIL %s: bus differs (unknown bits)", nm);
        end
    endtask

    task automatic push_ev(input bit sw, input logic [LW-1:0] l);
        ev_t e;
        e.is_swap = sw;
        e.lut     = l;
        evq.push_back(e);
    endtask

    function automatic int word_of(input vec_t v, input int k);
        if (k == v.bump_idx) return v.bump_val;
        return v.start - v.step * k;
    endfunction

    // Scoreboard: every load_err / swap_done pulse must match the next expected event.
    always @(negedge clk) begin
        if (load_err === 1'b1 || swap_done === 1'b1) begin
            if (evq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: load_err=%0b swap_done=%0b, required none",
                         load_err, swap_done);
            end else begin
                ev_t e;
                e = evq.pop_front();
                chk("event_swap_done", 32'(swap_done), 32'(e.is_swap));
                chk("event_load_err", 32'(load_err), 32'(!e.is_swap));
                if (e.is_swap) chk_lut("lut_at_swap_done", e.lut);
            end
        end
    end

    task automatic apply_reset();
        cfg_valid   = 1'b0;
        cfg_last    = 1'b0;
        frame_start = 1'b0;
        cfg_data    = '0;
        rst_n       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        model = all_rst;
    endtask

    task automatic do_beat(input int d, input bit last, input bit fs);
        int t;
        t           = 0;
        cfg_data    = DW'(d);
        cfg_last    = last;
        frame_start = fs;
        cfg_valid   = 1'b1;
        while (cfg_ready !== 1'b1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (cfg_ready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout: cfg_ready=%0b after %0d cycles, required 1", cfg_ready, t);
        end
        @(posedge clk);
        #1;
        cfg_valid   = 1'b0;
        cfg_last    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic run_case(input vec_t v);
        logic [LW-1:0] ld;
        ld = model;
        for (int k = 0; k < N; k++) ld[k*DW +: DW] = DW'(word_of(v, k));
        chk($sformatf("c%0d_ready_before", v.id), 32'(cfg_ready), 32'd1);
        for (int b = 1; b <= v.nbeats; b++) begin
            if (b == v.nbeats && v.exp_err) push_ev(1'b0, '0);
            do_beat(word_of(v, b - 1), b == v.last_at, v.collide && b == v.nbeats);
        end
        if (v.collide) chk($sformatf("c%0d_collide_no_swap", v.id), 32'(swap_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("c%0d_pending", v.id), 32'(pending), 32'(v.exp_pend));
        chk($sformatf("c%0d_ready", v.id), 32'(cfg_ready), 32'(!v.exp_pend));
        chk($sformatf("c%0d_wr_idx", v.id), 32'(wr_idx), 32'd0);
        chk_lut($sformatf("c%0d_lut_held", v.id), model);
        chk($sformatf("c%0d_events_after_load", v.id), 32'(evq.size()), 32'd0);
        if (v.exp_pend) begin
            repeat (8) @(posedge clk);
            #1;
            chk($sformatf("c%0d_pending_wait", v.id), 32'(pending), 32'd1);
            chk_lut($sformatf("c%0d_lut_wait", v.id), model);
            model = ld;
            push_ev(1'b1, ld);
            pulse_fs();
            chk_lut($sformatf("c%0d_lut_swapped", v.id), model);
            chk($sformatf("c%0d_entry0", v.id), 32'(lut_flat[0 +: DW]), 32'(word_of(v, 0)));
            chk($sformatf("c%0d_entry45", v.id), 32'(lut_flat[45*DW +: DW]), 32'(word_of(v, 45)));
            chk($sformatf("c%0d_pending_clr", v.id), 32'(pending), 32'd0);
        end else begin
            pulse_fs();
            repeat (2) @(posedge clk);
            #1;
            chk_lut($sformatf("c%0d_lut_unchanged", v.id), model);
        end
        repeat (2) @(posedge clk);
        #1;
        chk($sformatf("c%0d_events_drained", v.id), 32'(evq.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) all_rst[k*DW +: DW] = DW'(121);
        vt[0] = '{0, 46, 46, 400, 8, -1, 0, 1'b0, 1'b0, 1'b1};
        vt[1] = '{1, 30, 30, 300, 2, -1, 0, 1'b0, 1'b1, 1'b0};
        vt[2] = '{2, 46, 0, 350, 5, -1, 0, 1'b0, 1'b1, 1'b0};
        vt[3] = '{3, 46, 46, 500, 10, -1, 0, 1'b1, 1'b0, 1'b1};
        vt[4] = '{4, 46, 46, 250, 5, 11, 201, 1'b0, MONO_ON, !MONO_ON};
        vt[5] = '{5, 46, 46, 250, 5, 11, 200, 1'b0, 1'b0, 1'b1};
        vt[6] = '{6, 1, 1, 77, 0, -1, 0, 1'b0, 1'b1, 1'b0};
        vt[7] = '{7, 46, 46, 450, 10, -1, 0, 1'b0, 1'b0, 1'b1};
        vt[8] = '{8, 46, 46, 511, 0, -1, 0, 1'b0, 1'b0, 1'b1};

        apply_reset();
        chk_lut("reset_lut", all_rst);
        chk("reset_ready", 32'(cfg_ready), 32'd1);
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_swap_done", 32'(swap_done), 32'd0);
        chk("reset_load_err", 32'(load_err), 32'd0);
        chk("reset_wr_idx", 32'(wr_idx), 32'd0);
        chk("reset_no_x", 32'($isunknown(lut_flat)), 32'd0);

        for (int i = 0; i < 9; i++) run_case(vt[i]);

        // Long load: error on the beat at index 45, the 47th beat opens a new load.
        apply_reset();
        push_ev(1'b0, '0);
        for (int b = 1; b <= 46; b++) do_beat(300 - b, 1'b0, 1'b0);
        chk("long_err_pulse", 32'(load_err), 32'd1);
        chk("long_wr_idx_zero", 32'(wr_idx), 32'd0);
        do_beat(10, 1'b0, 1'b0);
        chk("long_wr_idx_restart", 32'(wr_idx), 32'd1);
        chk("long_pending", 32'(pending), 32'd0);
        chk_lut("long_lut_unchanged", model);

        // Words offered during PEND are held off and do not disturb the pending table.
        apply_reset();
        for (int b = 1; b <= 46; b++) do_beat(300 - 6 * (b - 1), b == 46, 1'b0);
        cfg_valid = 1'b1;
        cfg_data  = DW'(5);
        repeat (4) @(posedge clk);
        #1;
        chk("held_wr_idx", 32'(wr_idx), 32'd0);
        chk("held_ready", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
        for (int k = 0; k < N; k++) model[k*DW +: DW] = DW'(300 - 6 * k);
        push_ev(1'b1, model);
        pulse_fs();
        chk("held_entry0", 32'(lut_flat[0 +: DW]), 32'd300);
        chk_lut("held_lut", model);

        // Reset while PEND discards the waiting table.
        for (int b = 1; b <= 46; b++) do_beat(200 - 4 * (b - 1), b == 46, 1'b0);
        @(posedge clk);
        #1;
        chk("pend_before_reset", 32'(pending), 32'd1);
        apply_reset();
        chk("pend_after_reset", 32'(pending), 32'd0);
        chk_lut("lut_after_pend_reset", all_rst);
        pulse_fs();
        repeat (2) @(posedge clk);
        #1;
        chk_lut("lut_after_reset_fs", all_rst);
        chk("final_events_drained", 32'(evq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exp_lut_ctrl.md
Name: exp_lut_ctrl

Overview:
Configuration controller for the over-exposure correction exp interpolator's 46-entry curve table (y1_0..y1_45). It accepts table words from a register/CPU-side stream into a shadow bank, then swaps the shadow bank into the active bank only at a frame boundary. The exp datapath never sees a half-written curve. The active bank drives the exp table inputs as a flat bus.

Parameters:
DW_Y, 9, width of one table entry.
NUM, 46, number of table entries; fixed to the exp table size.
RST_VAL, 121, value of every active and shadow entry after reset.

Ports:
clk  input  1  clock.
rst_n  input  1  reset. Synchronous, active-high; name kept for codebase consistency.
cfg_valid  input  1  table word valid.
cfg_ready  output  1  controller can accept a word.
cfg_data  input  DW_Y  table word; the first word is entry 0.
cfg_last  input  1  marks the final word of a table load.
frame_start  input  1  one-cycle pulse at the start of each frame.
lut_flat  output  NUM*DW_Y  active table; entry k is bits [k*DW_Y +: DW_Y]. Drives y1_k.
pending  output  1  a complete shadow table is waiting for frame_start.
swap_done  output  1  one-cycle pulse when the active bank is updated.
load_err  output  1  one-cycle pulse when a malformed load is discarded.
wr_idx  output  6  next shadow index to be written, for debug.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - All shadow and active entries are set to RST_VAL.
  - State goes to IDLE; wr_idx=0.
  - pending=0, swap_done=0, load_err=0; cfg_ready=1 from the first cycle after reset.
  - Reset mid-load or mid-PEND discards everything.
- Beat: cfg_valid && cfg_ready at a clk edge. On a beat, shadow[wr_idx] <= cfg_data.
- States:
  - IDLE: cfg_ready=1. A beat without cfg_last goes to LOAD and sets wr_idx=1. A beat with cfg_last goes to error handling, unless NUM==1.
  - LOAD: cfg_ready=1. Each beat increments wr_idx.
    - cfg_last with wr_idx==NUM-1: go to PEND, wr_idx=0.
    - cfg_last with wr_idx<NUM-1: short load, error.
    - Beat at wr_idx==NUM-1 without cfg_last: long load, error.
  - Error handling: load_err pulses high for the cycle after the offending beat. State returns to IDLE, wr_idx=0. The active bank is untouched. Shadow contents are don't-care.
  - PEND: cfg_ready=0, pending=1. On frame_start, all NUM entries are copied shadow to active in one edge. swap_done is high the next cycle, and state returns to IDLE.
- frame_start in IDLE or LOAD is ignored; an in-progress load continues.
- Final beat and frame_start in the same cycle: the swap does not occur. PEND is entered first, and the swap waits for the next frame_start.
- lut_flat is a direct register output: the new table is visible the cycle after the frame_start edge. No other path changes the active bank.
- cfg_valid while cfg_ready=0 is held off. cfg_data must be held stable by the source until ready.
- Outputs never go X after reset. pending, swap_done and load_err are registered.

Optional Feature:
EXP_LUT_MONO_CHK_EN:
- When defined: during a load, every word at index k>0 must be <= the word at index k-1. The exp interpolator computes OL-(offset*(OL-OH)>>2) and requires a non-increasing curve.
  - A violating word sets a sticky flag for the current load.
  - At cfg_last the load is treated as an error: load_err pulses, state goes to IDLE, no PEND.
  - The flag clears on reset and on return to IDLE.
- When undefined: no ordering check, and any value is accepted.

Test Plan:
- Reset: after rst_n held high for 2 cycles then released, every lut_flat entry reads 121, cfg_ready=1, pending=0.
- Full load then swap:
  - Stimulus: 46 beats with entry k = 400-8k, cfg_last on beat 46, then a frame_start pulse 10 cycles later.
  - During the wait: pending=1, cfg_ready=0, lut_flat still all 121.
  - After the frame_start edge: lut_flat entries 0 and 45 read 400 and 40, and swap_done pulses once.
- Short load: 30 beats with cfg_last on beat 30 -> load_err pulses for 1 cycle, state back to IDLE, no pending, lut_flat unchanged even after frame_start.
- Long load: 47 beats, no cfg_last by beat 46 -> load_err on the beat at index 45, wr_idx=0, active bank unchanged.
- Collision: final beat in the same cycle as frame_start -> no swap and no swap_done. The next frame_start swaps.
- With EXP_LUT_MONO_CHK_EN defined: a 46-word load with entry 10=200 and entry 11=201 -> load_err at cfg_last, no PEND. The same load with entry 11=200 is accepted.
